seq_ctrl: RTL
=============

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001: Parameter SEND_NL, default 1, meaning: when 1, a SEND appends byte 0x0A after the two hex characters; when 0, it sends only the two hex characters.
REQ-002: Port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003: Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004: Port inst_vld, input, 1 bit: one-cycle strobe marking a new instruction.
REQ-005: Port inst_wd, input, 8 bits: instruction word, opcode in [7:6].
REQ-006: Port tx_rdy, input, 1 bit: UART transmitter ready to accept a byte.
REQ-007: Port tx_vld, output, 1 bit: tx_data holds a byte to transmit.
REQ-008: Port tx_data, output, 8 bits: byte to the UART transmitter.
REQ-009: Port led, output, 8 bits: last value written to or sent from the register file.
REQ-010: Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011: Port inst_drop, output, 1 bit: one-cycle pulse when inst_vld arrives while busy.

Function
REQ-012: Encoding SHALL be as follows:
- PUSH = 00,ra[5:4],immd[3:0]
- ADD = 01,ra,rb[3:2],rc[1:0]
- MULT = 10,ra,rb,rc
- SEND = 11,ra,xxxx
REQ-013: The FSM states SHALL be IDLE, EXEC, TX_HI, TX_LO, TX_NL.
REQ-014: In IDLE, inst_vld=1 SHALL latch inst_wd and move to EXEC on the next edge.
REQ-015: EXEC SHALL last exactly one cycle, as follows:
- PUSH/ADD/MULT: write the register file and led at the end of EXEC, then return to IDLE.
- SEND: load led with rf[ra], snapshot rf[ra], then go to TX_HI.
REQ-016: For an instruction strobed in cycle N, the written value SHALL be visible on the register file and led in cycle N+2, and busy SHALL be high in cycle N+1.
REQ-017: PUSH SHALL write {4'h0, immd} (zero-extended).
REQ-018: ADD SHALL write (rf[rb]+rf[rc]) mod 256; the carry is discarded.
REQ-019: MULT SHALL write the low 8 bits of rf[rb]*rf[rc].
REQ-020: ra SHALL equal rb or rc legally; the operands are read before the write.
REQ-021: Transmit states SHALL behave as follows:
- TX_HI presents the ASCII hex of snapshot[7:4]; TX_LO presents the ASCII hex of snapshot[3:0].
- Hex digits are uppercase: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
- TX_NL presents 0x0A.
REQ-022: tx_vld SHALL be 1 in every TX state, and tx_data SHALL stay stable until the cycle in which tx_vld and tx_rdy are both high.
REQ-023: On that handshake cycle the FSM SHALL advance: TX_HI->TX_LO, TX_LO->TX_NL (SEND_NL=1) or IDLE (SEND_NL=0), TX_NL->IDLE.
REQ-024: tx_rdy held low SHALL stall the FSM indefinitely with no timeout.
REQ-025: tx_vld SHALL be 0 in IDLE and EXEC.
REQ-026: inst_vld in any non-IDLE state SHALL be ignored and SHALL pulse inst_drop in the next cycle.
REQ-027: inst_vld in the same cycle the FSM returns to IDLE (the last handshake or the EXEC cycle) SHALL count as busy and be dropped.
REQ-028: A SEND SHALL transmit the snapshot value, unaffected by later state.

Reset
REQ-029: rst SHALL take priority over all other inputs, including mid-EXEC and mid-transmit.
REQ-030: rst SHALL force state IDLE and clear all four registers to 0x00.
REQ-031: rst SHALL clear led=0x00, tx_vld=0, tx_data=0x00, busy=0 and inst_drop=0 in the cycle after rst is sampled high.
REQ-032: A transmit interrupted by rst SHALL be abandoned, not resumed.

Structure
REQ-033: Package seq_pkg SHALL hold the opcode constants, state encoding, ASCII_LF, the ASCII digit/letter offsets, and the register-index width (2).
REQ-034: Sub-module seq_regfile SHALL implement 4x8 storage with two combinational read ports, one synchronous write port, and synchronous clear on rst.
REQ-035: seq_ctrl SHALL contain the FSM, ALU and hex conversion, and SHALL have no other sub-modules.

Verification
REQ-036: The following directed scenarios SHALL be covered:
- PUSH(0,4), PUSH(2,1), PUSH(1,3), MULT(0,1,2), ADD(2,0,3), SEND(2), with tx_rdy=1 -> bytes 0x30,0x33,0x0A, and led=0x03 after each of MULT, ADD and SEND.
- PUSH(1,0xF) x4 chain ADD(1,1,1) -> 0x0F,0x1E,0x3C,0x78,0xF0; then ADD(1,1,1) -> 0xE0 (carry dropped); MULT(0,1,1) -> 0x00.
- SEND of 0xE0 with tx_rdy low for 20 cycles per byte -> tx_data held at 0x45 for those cycles; sequence 0x45,0x30,0x0A; busy high throughout.
- inst_vld during EXEC and during TX_LO -> inst_drop pulses twice; register file and byte stream unchanged.
- rst asserted during TX_LO -> next cycle tx_vld=0, led=0x00; a subsequent SEND(3) emits 0x30,0x30,0x0A.
- SEND_NL=0 build, SEND of 0xA5 -> exactly two bytes 0x41,0x35, then IDLE.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the seq_ctrl instruction sequencer: opcodes, FSM states,
// register-index width and ASCII offsets used by the hex transmitter.
package seq_pkg;

    localparam int RIDX_W = 2;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_ADD  = 2'b01,
        OP_MULT = 2'b10,
        OP_SEND = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_TX_HI,
        ST_TX_LO,
        ST_TX_NL
    } state_e;

    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT_OFS = 8'h30;
    // 'A' minus 10, so a nibble of 10..15 maps straight onto 'A'..'F'
    localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;

endpackage

// File: rtl/seq_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port,
// synchronous clear.
module seq_regfile
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] raddr_a_i,
    output logic [7:0]        rdata_a_o,
    input  logic [RIDX_W-1:0] raddr_b_i,
    output logic [7:0]        rdata_b_o,
    input  logic              we_i,
    input  logic [RIDX_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i
);

    logic [(1<<RIDX_W)-1:0][7:0] rf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q <= '0;
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = rf_q[raddr_a_i];
    assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/seq_ctrl.sv
// Instruction sequencer: decodes PUSH/ADD/MULT/SEND, runs the ALU and streams
// a register value as two uppercase hex characters (plus optional LF).
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int SEND_NL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inst_vld,
    input  logic [7:0] inst_wd,
    input  logic       tx_rdy,
    output logic       tx_vld,
    output logic [7:0] tx_data,
    output logic [7:0] led,
    output logic       busy,
    output logic       inst_drop
);

    state_e            state_q, state_d;
    logic [7:0]        inst_q, inst_d;
    logic [7:0]        snap_q, snap_d;
    logic [7:0]        led_q, led_d;
    logic              drop_q, drop_d;

    opcode_e           op;
    logic [RIDX_W-1:0] ra, rb, rc, raddr_a;
    logic [7:0]        rd_a, rd_b, alu;
    logic              we;

    assign op = opcode_e'(inst_q[7:6]);
    assign ra = inst_q[5:4];
    assign rb = inst_q[3:2];
    assign rc = inst_q[1:0];
    // Port A serves rb for arithmetic and ra for SEND; ADD/MULT never need ra read
    assign raddr_a = (op == OP_SEND) ? ra : rb;

    seq_regfile u_rf (
        .clk       (clk),
        .rst       (rst),
        .raddr_a_i (raddr_a),
        .rdata_a_o (rd_a),
        .raddr_b_i (rc),
        .rdata_b_o (rd_b),
        .we_i      (we),
        .waddr_i   (ra),
        .wdata_i   (alu)
    );

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? ASCII_DIGIT_OFS + {4'h0, nib}
                             : ASCII_ALPHA_OFS + {4'h0, nib};
    endfunction

    always_comb begin
        alu = '0;
        case (op)
            OP_PUSH: alu = {4'h0, inst_q[3:0]};
            OP_ADD:  alu = rd_a + rd_b;
            OP_MULT: alu = rd_a * rd_b;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
            snap_q  <= '0;
            led_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            snap_q  <= snap_d;
            led_q   <= led_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        snap_d  = snap_q;
        led_d   = led_q;
        drop_d  = inst_vld && (state_q != ST_IDLE);
        we      = 1'b0;
        tx_vld  = 1'b0;
        tx_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (inst_vld) begin
                    inst_d  = inst_wd;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op == OP_SEND) begin
                    led_d   = rd_a;
                    snap_d  = rd_a;
                    state_d = ST_TX_HI;
                end else begin
                    we      = 1'b1;
                    led_d   = alu;
                    state_d = ST_IDLE;
                end
            end
            ST_TX_HI: begin
                tx_vld  = 1'b1;
                tx_data = hex_ascii(snap_q[7:4]);
                if (tx_rdy) state_d = ST_TX_LO;
            end
            ST_TX_LO: begin
                tx_vld  = 1'b1;
                tx_data = hex_ascii(snap_q[3:0]);
                if (tx_rdy) state_d = (SEND_NL != 0) ? ST_TX_NL : ST_IDLE;
            end
            ST_TX_NL: begin
                tx_vld  = 1'b1;
                tx_data = ASCII_LF;
                if (tx_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign led       = led_q;
    assign busy      = (state_q != ST_IDLE);
    assign inst_drop = drop_q;

endmodule
